// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader that fills CPU instruction memory,
// holding the CPU halted until a frame's checksum passes.
module program_loader #(
    parameter int         ADDR_W   = 11,
    parameter logic [7:0] HEADER   = 8'hA5,
    parameter int         TIMEOUT  = 50000,
    parameter bit         AUTO_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [31:0]       w_instruction,
    output logic              w_enable,
    output logic [ADDR_W-1:0] w_adrs,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHECK, RUN, ERROR} state_t;

    state_t            state, state_n;
    logic [7:0]        hi, chk;
    logic [15:0]       cnt, cnt_word;
    logic [23:0]       word;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] adr;
    logic [TW-1:0]     timer;
    logic              start, timeout;

    assign busy     = state inside {ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHECK};
    assign cpu_en   = state == RUN;
    assign error    = state == ERROR;
    assign cnt_word = {hi, rx_data};
    assign start    = rx_valid && rx_data == HEADER && state inside {IDLE, RUN, ERROR};
    assign timeout  = busy && !rx_valid && timer == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (timeout) state_n = ERROR;
        else if (start) state_n = ADDR_HI;
        else if (rx_valid)
            case (state)
                ADDR_HI: state_n = ADDR_LO;
                ADDR_LO: state_n = CNT_HI;
                CNT_HI:  state_n = CNT_LO;
                CNT_LO:  state_n = {16'd0, cnt_word} > (32'd1 << ADDR_W) ? ERROR : cnt_word == 16'd0 ? CHECK : DATA;
                DATA:    state_n = idx == 2'd3 && cnt == 16'd1 ? CHECK : DATA;
                CHECK:   state_n = chk != rx_data ? ERROR : AUTO_RUN ? RUN : IDLE;
                default: state_n = state;
            endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_instruction <= '0;
            w_enable      <= 1'b0;
            w_adrs        <= '0;
            done          <= 1'b0;
            hi            <= '0;
            chk           <= '0;
            cnt           <= '0;
            word          <= '0;
            idx           <= '0;
            adr           <= '0;
            timer         <= '0;
        end else begin
            w_enable <= 1'b0;
            timer    <= rx_valid || !busy ? '0 : timer + TW'(1);
            if (start) begin
                chk  <= '0;
                done <= 1'b0;
                idx  <= '0;
            end else if (rx_valid && busy) begin
                // CHK also folds into chk here; it is cleared again at the next header
                chk <= chk ^ rx_data;
                case (state)
                    ADDR_HI, CNT_HI: hi <= rx_data;
                    ADDR_LO: adr <= ADDR_W'(cnt_word);
                    CNT_LO:  cnt <= cnt_word;
                    DATA: begin
                        word <= {word[15:0], rx_data};
                        idx  <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            w_instruction <= {word, rx_data};
                            w_adrs        <= adr;
                            w_enable      <= 1'b1;
                            adr           <= adr + ADDR_W'(1);
                            cnt           <= cnt - 16'd1;
                        end
                    end
                    CHECK:   done <= chk == rx_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: frame-level reference model (expected write queue and end flags)
// driven by a vector table, hand sequences for timing corners, and random frames.
module tb_program_loader;
    localparam int TO = 64;

    logic        clk, reset, rx_valid, w_enable, cpu_en, busy, done, error;
    logic [7:0]  rx_data;
    logic [31:0] w_instruction;
    logic [10:0] w_adrs;

    int compared = 0;
    int mismatched = 0;
    logic [42:0] exp_q[$];

    program_loader #(.ADDR_W(11), .HEADER(8'hA5), .TIMEOUT(TO), .AUTO_RUN(1'b1)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .w_instruction(w_instruction), .w_enable(w_enable), .w_adrs(w_adrs),
        .cpu_en(cpu_en), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (w_enable) begin
            logic [42:0] e;
            check("cpu_en_during_write", 64'(cpu_en), 64'(0));
            check("write_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("w_adrs", 64'(w_adrs), 64'(e[42:32]));
                check("w_instruction", 64'(w_instruction), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (int'($urandom_range(32'(maxgap), 0))) @(negedge clk);
    endtask

    task automatic send_body(input logic [15:0] adr, input logic [15:0] cnt, input logic [31:0] base,
                             input logic [7:0] chk_x, input int maxgap);
        logic [7:0]  c;
        logic [31:0] w;
        c = adr[15:8] ^ adr[7:0] ^ cnt[15:8] ^ cnt[7:0];
        send_byte(adr[15:8], maxgap);
        send_byte(adr[7:0], maxgap);
        send_byte(cnt[15:8], maxgap);
        send_byte(cnt[7:0], maxgap);
        if (cnt > 16'd2048) return;
        for (int i = 0; i < int'(cnt); i++) begin
            w = base + 32'(i) * 32'h01010101;
            exp_q.push_back({11'(adr + 16'(i)), w});
            for (int k = 3; k >= 0; k--) begin
                c = c ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], maxgap);
            end
        end
        send_byte(c ^ chk_x, maxgap);
    endtask

    task automatic send_frame(input logic [15:0] adr, input logic [15:0] cnt, input logic [31:0] base,
                              input logic [7:0] chk_x, input int maxgap);
        send_byte(8'hA5, maxgap);
        send_body(adr, cnt, base, chk_x, maxgap);
    endtask

    task automatic check_flags(input logic d, input logic e, input logic r);
        check("busy", 64'(busy), 64'(0));
        check("done", 64'(done), 64'(d));
        check("error", 64'(error), 64'(e));
        check("cpu_en", 64'(cpu_en), 64'(r));
    endtask

    task automatic check_all_zero();
        check("rst_w_enable", 64'(w_enable), 64'(0));
        check("rst_w_adrs", 64'(w_adrs), 64'(0));
        check("rst_w_instruction", 64'(w_instruction), 64'(0));
        check("rst_cpu_en", 64'(cpu_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
    endtask

    typedef struct {
        logic [15:0] adr;
        logic [15:0] cnt;
        logic [31:0] base;
        logic [7:0]  chk_x;
        logic        done, err, run;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{16'h0007, 16'd1,    32'h12345678, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{16'h07FF, 16'd2,    32'h11111111, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h0007, 16'd1,    32'h12345678, 8'h01, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h0007, 16'd1,    32'h12345678, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'hF805, 16'd3,    32'hA5A5A5A5, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{16'h0000, 16'd0,    32'h00000000, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h0100, 16'd2049, 32'h00000000, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{16'h0005, 16'd2048, 32'hDEADBEEF, 8'h00, 1'b1, 1'b0, 1'b1};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero();
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h3C, 0);
        check("idle_ignores_byte", 64'(busy), 64'(0));

        for (int v = 0; v < 8; v++) begin
            send_frame(tbl[v].adr, tbl[v].cnt, tbl[v].base, tbl[v].chk_x, v % 2);
            check_flags(tbl[v].done, tbl[v].err, tbl[v].run);
            @(negedge clk);
            check("writes_left", 64'(exp_q.size()), 64'(0));
        end

        // reload while running
        send_byte(8'hA5, 0);
        check("reload_cpu_en", 64'(cpu_en), 64'(0));
        check("reload_busy", 64'(busy), 64'(1));
        send_body(16'h0123, 16'd2, 32'hCAFE0000, 8'h00, 0);
        check_flags(1'b1, 1'b0, 1'b1);
        check("reload_writes_left", 64'(exp_q.size()), 64'(0));

        // inter-byte timeout boundary
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        repeat (TO - 1) @(negedge clk);
        check("timeout_not_yet_error", 64'(error), 64'(0));
        check("timeout_not_yet_busy", 64'(busy), 64'(1));
        @(negedge clk);
        check("timeout_error", 64'(error), 64'(1));
        check("timeout_busy", 64'(busy), 64'(0));
        check("timeout_cpu_en", 64'(cpu_en), 64'(0));

        // async reset mid-DATA: nothing queued, so any write is flagged
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #3 reset = 1'b1;
        #1 check_all_zero();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_idle", 64'(busy), 64'(0));
        send_frame(16'h0000, 16'd0, 32'h0, 8'h00, 0);
        check_flags(1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] adr, cnt;
            logic [7:0]  cx, junk;
            logic        bad;
            adr = 16'($urandom);
            cnt = ($urandom_range(9, 0) == 0) ? 16'($urandom_range(65535, 2049)) : 16'($urandom_range(5, 0));
            cx  = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            bad = cnt > 16'd2048 || cx != 8'h00;
            send_frame(adr, cnt, $urandom, cx, 3);
            check_flags(!bad, bad, !bad);
            repeat (int'($urandom_range(3, 0))) begin
                junk = 8'($urandom);
                send_byte(junk == 8'hA5 ? 8'h5A : junk, 1);
            end
            check_flags(!bad, bad, !bad);
            check("rand_writes_left", 64'(exp_q.size()), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
